// File: rtl/diode_pkg.sv
// -----------------------------------------------------------------------------
// diode_pkg
//   Shared types and constants for the photodiode exposure pulse generator.
//   - state_e      : sequencer states (IDLE, DELAY, PULSE, GAP)
//   - MODE_*       : encodings of the cfg_mode input
//   - DEF_DELAY/DEF_WIDTH : nominal exposure timing at 200 MHz, in clocks
//   - is_busy()    : true for every state other than IDLE
// -----------------------------------------------------------------------------
package diode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BURST  = 1'b1;

    // 2.2 us delay and 1.2 us exposure at 200 MHz.
    localparam int unsigned DEF_DELAY = 440;
    localparam int unsigned DEF_WIDTH = 240;

    function automatic logic is_busy(input state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/diode_pulse_gen_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous level into the clock domain through a SYNC_LEN-deep
//   flop chain and emits a registered one-cycle pulse on its rising edge.
//   The pulse appears SYNC_LEN+1 cycles after the input rises.
// Ports
//   clk     in  1  clock
//   rst     in  1  asynchronous, active-high reset
//   async_i in  1  asynchronous level input
//   rise_o  out 1  one-cycle rising-edge pulse, registered
// -----------------------------------------------------------------------------
module sync_edge_det
    import diode_pkg::*;
#(
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_LEN-1:0] sync_q, sync_d;
    logic                prev_q, prev_d;
    logic                rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_LEN-2:0], async_i};
        prev_d = sync_q[SYNC_LEN-1];
        rise_d = sync_q[SYNC_LEN-1] & ~prev_q;
    end

    // NOTE: flops use non-blocking assignments so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/diode_pulse_gen.sv
// -----------------------------------------------------------------------------
// diode_pulse_gen
//   Multi-channel exposure pulse generator for the photodiode line. A trigger
//   (synchronised rising edge of stm_signal, or signal_to_diods_request) starts
//   a sequence: programmable delay, then one (single) or cfg_burst (burst)
//   strobes of programmable width separated by a programmable gap.
// Ports
//   clk_200MHz_i            in  1        sole clock
//   reset                   in  1        asynchronous, active-high reset
//   stm_signal              in  1        async MCU trigger level
//   signal_to_diods_request in  1        synchronous trigger pulse
//   cfg_delay/width/gap     in  CNT_W    timing, in clocks
//   cfg_burst               in  BURST_W  pulses per trigger in burst mode
//   cfg_mode                in  1        MODE_SINGLE / MODE_BURST
//   cfg_ch_mask             in  N_CH     channel enable mask
//   abort                   in  1        synchronous abort
//   ack_clr                 in  1        clears the sticky flags
//   signal_to_diods         out N_CH     registered strobes
//   stm_signal_output       out 1        sticky "trigger seen"
//   busy                    out 1        sequencer not idle
//   done                    out 1        one-cycle end-of-sequence pulse
//   overrun                 out 1        sticky "trigger while busy"
// -----------------------------------------------------------------------------
module diode_pulse_gen
    import diode_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int BURST_W  = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic               clk_200MHz_i,
    input  logic               reset,
    input  logic               stm_signal,
    input  logic               signal_to_diods_request,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               cfg_mode,
    input  logic [N_CH-1:0]    cfg_ch_mask,
    input  logic               abort,
    input  logic               ack_clr,
    output logic [N_CH-1:0]    signal_to_diods,
    output logic               stm_signal_output,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    // ---------------------------------------------------------------- trigger
    logic stm_rise;
    logic trig;

    sync_edge_det #(.SYNC_LEN(SYNC_LEN)) u_stm_sync (
        .clk     (clk_200MHz_i),
        .rst     (reset),
        .async_i (stm_signal),
        .rise_o  (stm_rise)
    );

    assign trig = stm_rise | signal_to_diods_request;

    // ------------------------------------------------------------------ state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // shared delay/width/gap counter
    logic [BURST_W-1:0] rem_q, rem_d;       // pulse slots still to run
    // Delay, mode and burst count are consumed at trigger acceptance (into
    // cnt_q/rem_q); only the values used later in the sequence are shadowed.
    logic [CNT_W-1:0]   sh_width_q, sh_width_d;
    logic [CNT_W-1:0]   sh_gap_q, sh_gap_d;
    logic [N_CH-1:0]    sh_mask_q, sh_mask_d;
    logic [N_CH-1:0]    strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               stm_flag_q, stm_flag_d;
    logic               overrun_q, overrun_d;

    logic               accept;
    logic               abort_hit;
    logic [CNT_W-1:0]   eff_width;
    logic [CNT_W-1:0]   eff_gap;
    logic [N_CH-1:0]    eff_mask;

    assign accept    = (state_q == IDLE) && trig && !abort;
    assign abort_hit = is_busy(state_q) && abort;

    // On the accepting cycle the shadows are not loaded yet, so the slot logic
    // reads the cfg inputs directly; afterwards it reads the shadows.
    assign eff_width = (state_q == IDLE) ? cfg_width   : sh_width_q;
    assign eff_gap   = (state_q == IDLE) ? cfg_gap     : sh_gap_q;
    assign eff_mask  = (state_q == IDLE) ? cfg_ch_mask : sh_mask_q;

    // -------------------------------------------------------- state register
    always_ff @(posedge clk_200MHz_i or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            sh_width_q <= '0;
            sh_gap_q   <= '0;
            sh_mask_q  <= '0;
            strobe_q   <= '0;
            done_q     <= 1'b0;
            stm_flag_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            sh_width_q <= sh_width_d;
            sh_gap_q   <= sh_gap_d;
            sh_mask_q  <= sh_mask_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            stm_flag_q <= stm_flag_d;
            overrun_q  <= overrun_d;
        end
    end

    // ------------------------------------------------------ next-state logic
    logic               enter_slot;   // start a pulse slot this cycle
    logic               end_slot;     // a pulse slot finishes this cycle
    logic [BURST_W-1:0] slot_rem;     // slots outstanding before this one ends
    logic [BURST_W-1:0] rem_left;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        sh_width_d = sh_width_q;
        sh_gap_d   = sh_gap_q;
        sh_mask_d  = sh_mask_q;
        enter_slot = 1'b0;
        end_slot   = 1'b0;
        slot_rem   = rem_q;
        rem_left   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_width_d = cfg_width;
                    sh_gap_d   = cfg_gap;
                    sh_mask_d  = cfg_ch_mask;
                    // A zero burst count still runs one pulse.
                    slot_rem   = (cfg_mode == MODE_BURST && cfg_burst != '0)
                                 ? cfg_burst : BURST_W'(1);
                    rem_d      = slot_rem;
                    if (cfg_delay == '0) begin
                        enter_slot = 1'b1;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = cfg_delay;
                    end
                end
            end
            DELAY, GAP: begin
                if (cnt_q <= CNT_W'(1)) enter_slot = 1'b1;
                else                    cnt_d = cnt_q - CNT_W'(1);
            end
            PULSE: begin
                if (cnt_q <= CNT_W'(1)) end_slot = 1'b1;
                else                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // A zero-width slot takes no cycles: it is consumed as it starts.
        if (enter_slot) begin
            if (eff_width != '0) begin
                state_d = PULSE;
                cnt_d   = eff_width;
            end else begin
                end_slot = 1'b1;
            end
        end

        if (end_slot) begin
            rem_left = slot_rem - BURST_W'(1);
            rem_d    = rem_left;
            if (rem_left == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (eff_gap != '0) begin
                state_d = GAP;
                cnt_d   = eff_gap;
            end else if (eff_width != '0) begin
                state_d = PULSE;        // back-to-back pulses
                cnt_d   = eff_width;
            end else begin
                state_d = GAP;          // zero width and zero gap: one idle slot cycle
                cnt_d   = '0;
            end
        end

        if (abort_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
            rem_d   = '0;
        end
    end

    // ---------------------------------------------------------- output logic
    always_comb begin
        // Strobes are registered from the next state so they line up with it.
        strobe_d   = (state_d == PULSE) ? eff_mask : '0;
        done_d     = is_busy(state_q) && (state_d == IDLE) && !abort_hit;
        // Set beats clear when a trigger and ack_clr coincide.
        stm_flag_d = trig ? 1'b1 : (ack_clr ? 1'b0 : stm_flag_q);
        overrun_d  = (trig && is_busy(state_q)) ? 1'b1
                   : (ack_clr ? 1'b0 : overrun_q);
    end

    assign signal_to_diods   = strobe_q;
    assign stm_signal_output = stm_flag_q;
    assign busy              = is_busy(state_q);
    assign done              = done_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_diode_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_diode_pulse_gen
//   Directed bench for diode_pulse_gen. Cycle index k counts clock edges after
//   the edge that consumed the trigger; outputs are sampled 1 time unit after
//   each rising edge.
// -----------------------------------------------------------------------------
module tb_diode_pulse_gen;
    import diode_pkg::*;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clk_200MHz_i = 1'b0;
    logic               reset;
    logic               stm_signal;
    logic               signal_to_diods_request;
    logic [CNT_W-1:0]   cfg_delay;
    logic [CNT_W-1:0]   cfg_width;
    logic [CNT_W-1:0]   cfg_gap;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_mode;
    logic [N_CH-1:0]    cfg_ch_mask;
    logic               abort;
    logic               ack_clr;
    logic [N_CH-1:0]    signal_to_diods;
    logic               stm_signal_output;
    logic               busy;
    logic               done;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk_200MHz_i = ~clk_200MHz_i;

    diode_pulse_gen #(
        .N_CH(N_CH), .CNT_W(CNT_W), .BURST_W(BURST_W), .SYNC_LEN(2)
    ) dut (
        .clk_200MHz_i            (clk_200MHz_i),
        .reset                   (reset),
        .stm_signal              (stm_signal),
        .signal_to_diods_request (signal_to_diods_request),
        .cfg_delay               (cfg_delay),
        .cfg_width               (cfg_width),
        .cfg_gap                 (cfg_gap),
        .cfg_burst               (cfg_burst),
        .cfg_mode                (cfg_mode),
        .cfg_ch_mask             (cfg_ch_mask),
        .abort                   (abort),
        .ack_clr                 (ack_clr),
        .signal_to_diods         (signal_to_diods),
        .stm_signal_output       (stm_signal_output),
        .busy                    (busy),
        .done                    (done),
        .overrun                 (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_200MHz_i);
        #1;
    endtask

    // Request is sampled at the next edge; on return we sit in cycle k=1.
    task automatic pulse_req();
        signal_to_diods_request = 1'b1;
        tick();
        signal_to_diods_request = 1'b0;
    endtask

    task automatic clear_flags();
        ack_clr = 1'b1;
        tick();
        ack_clr = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int hi_cnt;
    int done_cnt;
    int first_hi;
    logic [N_CH-1:0] exp_s;

    initial begin
        reset = 1'b1;
        stm_signal = 1'b0;
        signal_to_diods_request = 1'b0;
        cfg_delay = CNT_W'(DEF_DELAY);
        cfg_width = CNT_W'(DEF_WIDTH);
        cfg_gap = '0;
        cfg_burst = '0;
        cfg_mode = MODE_SINGLE;
        cfg_ch_mask = 4'b1011;
        abort = 1'b0;
        ack_clr = 1'b0;

        // ---- reset state
        idle_cycles(3);
        check("rst_strobe", 32'(signal_to_diods), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_stm_out", 32'(stm_signal_output), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        idle_cycles(2);

        // ---- single shot, delay 440, width 240, mask 1011
        hi_cnt = 0;
        done_cnt = 0;
        pulse_req();
        for (int k = 1; k <= 700; k++) begin
            if (k > 1) tick();
            if (signal_to_diods != '0) hi_cnt++;
            if (done) done_cnt++;
            case (k)
                1: begin
                    check("single_busy_k1", 32'(busy), 32'h1);
                    check("single_strobe_k1", 32'(signal_to_diods), 32'h0);
                    check("single_stm_out_k1", 32'(stm_signal_output), 32'h1);
                end
                440: check("single_strobe_k440", 32'(signal_to_diods), 32'h0);
                441: check("single_strobe_k441", 32'(signal_to_diods), 32'hb);
                680: check("single_strobe_k680", 32'(signal_to_diods), 32'hb);
                681: begin
                    check("single_strobe_k681", 32'(signal_to_diods), 32'h0);
                    check("single_done_k681", 32'(done), 32'h1);
                    check("single_busy_k681", 32'(busy), 32'h0);
                end
                682: check("single_done_k682", 32'(done), 32'h0);
                default: ;
            endcase
        end
        check("single_hi_cycles", 32'(hi_cnt), 32'd240);
        check("single_done_count", 32'(done_cnt), 32'd1);
        check("single_overrun", 32'(overrun), 32'h0);
        clear_flags();
        check("ack_clr_stm_out", 32'(stm_signal_output), 32'h0);

        // ---- burst of 3: delay 0, width 5, gap 4
        cfg_delay = 16'd0;
        cfg_width = 16'd5;
        cfg_gap = 16'd4;
        cfg_burst = 8'd3;
        cfg_mode = MODE_BURST;
        cfg_ch_mask = 4'b1111;
        pulse_req();
        for (int k = 1; k <= 28; k++) begin
            if (k > 1) tick();
            exp_s = ((k >= 1 && k <= 5) || (k >= 10 && k <= 14) || (k >= 19 && k <= 23))
                    ? 4'hf : 4'h0;
            check($sformatf("burst_strobe_k%0d", k), 32'(signal_to_diods), 32'(exp_s));
            check($sformatf("burst_done_k%0d", k), 32'(done), 32'(k == 24));
        end
        clear_flags();

        // ---- second request during PULSE: timing unchanged, overrun set
        cfg_delay = 16'd2;
        cfg_width = 16'd6;
        cfg_mode = MODE_SINGLE;
        cfg_ch_mask = 4'b0001;
        pulse_req();                       // k=1
        idle_cycles(3);                    // k=4, strobe high since k=3
        check("ovr_strobe_k4", 32'(signal_to_diods), 32'h1);
        pulse_req();                       // consumed while busy, k=5
        check("ovr_overrun_k5", 32'(overrun), 32'h1);
        idle_cycles(3);                    // k=8
        check("ovr_strobe_k8", 32'(signal_to_diods), 32'h1);
        tick();                            // k=9
        check("ovr_strobe_k9", 32'(signal_to_diods), 32'h0);
        check("ovr_done_k9", 32'(done), 32'h1);
        idle_cycles(3);
        check("ovr_no_restart", 32'(busy), 32'h0);
        clear_flags();
        check("ovr_cleared", 32'(overrun), 32'h0);
        check("ovr_stm_out_cleared", 32'(stm_signal_output), 32'h0);

        // ---- stm_signal held high: one sequence, SYNC_LEN+1 trigger latency
        cfg_delay = 16'd1;
        cfg_width = 16'd2;
        cfg_ch_mask = 4'b0110;
        hi_cnt = 0;
        done_cnt = 0;
        first_hi = 0;
        stm_signal = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (signal_to_diods != '0) begin
                hi_cnt++;
                if (first_hi == 0) first_hi = k;
            end
            if (done) done_cnt++;
        end
        check("stm_first_strobe", 32'(first_hi), 32'd5);
        check("stm_hi_cycles", 32'(hi_cnt), 32'd2);
        check("stm_done_count", 32'(done_cnt), 32'd1);
        check("stm_overrun", 32'(overrun), 32'h0);
        stm_signal = 1'b0;
        idle_cycles(10);
        check("stm_out_sticky", 32'(stm_signal_output), 32'h1);
        clear_flags();
        check("stm_out_cleared", 32'(stm_signal_output), 32'h0);

        // ---- abort mid-PULSE of a burst
        cfg_delay = 16'd0;
        cfg_width = 16'd5;
        cfg_gap = 16'd4;
        cfg_burst = 8'd3;
        cfg_mode = MODE_BURST;
        cfg_ch_mask = 4'b1111;
        pulse_req();                       // k=1
        idle_cycles(2);                    // k=3, mid first pulse
        check("abort_pre_strobe", 32'(signal_to_diods), 32'hf);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_strobe", 32'(signal_to_diods), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        hi_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (signal_to_diods != '0) hi_cnt++;
            if (done) done_cnt++;
        end
        check("abort_quiet_strobe", 32'(hi_cnt), 32'd0);
        check("abort_quiet_done", 32'(done_cnt), 32'd0);
        check("abort_flag_kept", 32'(stm_signal_output), 32'h1);
        clear_flags();

        // ---- abort together with a trigger in IDLE starts nothing
        abort = 1'b1;
        pulse_req();
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'h0);
        idle_cycles(3);
        check("abort_idle_strobe", 32'(signal_to_diods), 32'h0);
        clear_flags();

        // ---- reset asserted mid-DELAY
        cfg_delay = 16'd100;
        cfg_width = 16'd10;
        cfg_mode = MODE_SINGLE;
        pulse_req();
        idle_cycles(4);
        check("rstmid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_stm_out", 32'(stm_signal_output), 32'h0);
        check("rstmid_strobe", 32'(signal_to_diods), 32'h0);
        reset = 1'b0;
        idle_cycles(2);

        // ---- width 0, delay 3: no strobe, done 4 cycles after trigger
        cfg_delay = 16'd3;
        cfg_width = 16'd0;
        hi_cnt = 0;
        pulse_req();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            if (signal_to_diods != '0) hi_cnt++;
            check($sformatf("w0_done_k%0d", k), 32'(done), 32'(k == 4));
            check($sformatf("w0_busy_k%0d", k), 32'(busy), 32'(k <= 3));
        end
        check("w0_no_strobe", 32'(hi_cnt), 32'd0);
        clear_flags();

        // ---- cfg changed during DELAY has no effect
        cfg_delay = 16'd10;
        cfg_width = 16'd3;
        cfg_ch_mask = 4'b1001;
        pulse_req();                       // k=1
        tick();                            // k=2
        cfg_delay = 16'd2;
        cfg_width = 16'd50;
        cfg_ch_mask = 4'b0110;
        idle_cycles(8);                    // k=10
        check("cfgchg_strobe_k10", 32'(signal_to_diods), 32'h0);
        tick();                            // k=11
        check("cfgchg_strobe_k11", 32'(signal_to_diods), 32'h9);
        idle_cycles(2);                    // k=13
        check("cfgchg_strobe_k13", 32'(signal_to_diods), 32'h9);
        tick();                            // k=14
        check("cfgchg_strobe_k14", 32'(signal_to_diods), 32'h0);
        check("cfgchg_done_k14", 32'(done), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
